ex_mem_dresp: RTL and testbench

//  Data-memory responder feeding the EX3 stage: drives memDataIn/memDataInB/memDataOK for loads/stores issued by EX1/EX2.

---
 rtl/ex_mem_dresp_pkg.sv | 48 ++++
 rtl/ex_mem_dresp_if.sv | 42 ++++
 rtl/ex_mem_dextract.sv | 30 +++
 rtl/ex_mem_dresp.sv | 149 ++++++++++++++
 tb/tb_ex_mem_dresp.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_mem_dresp_pkg.sv
// Shared definitions for the EX3 data-memory responder: FSM states, memDataOK codes,
// access sizes and small decode helpers.
package ex_mem_dresp_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StIssue = 3'd1,
        StWait  = 3'd2,
        StDone  = 3'd3,
        StFault = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OkReady = 2'b00,
        OkHold  = 2'b10,
        OkFault = 2'b11
    } mem_ok_e;

    typedef enum logic [1:0] {
        SizeB = 2'd0,
        SizeW = 2'd1,
        SizeL = 2'd2,
        SizeQ = 2'd3
    } size_e;

    function automatic logic [7:0] size_mask(size_e size);
        logic [7:0] mask;
        unique case (size)
            SizeB:   mask = 8'h01;
            SizeW:   mask = 8'h03;
            SizeL:   mask = 8'h0f;
            default: mask = 8'hff;
        endcase
        return mask;
    endfunction

    function automatic logic is_misaligned(size_e size, logic [2:0] addr_lo);
        logic mis;
        unique case (size)
            SizeB:   mis = 1'b0;
            SizeW:   mis = addr_lo[0];
            SizeL:   mis = |addr_lo[1:0];
            default: mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ex_mem_dresp_if.sv
// Request/response and bus signals of the data-memory responder.
// slave = the responder itself, master = pipeline plus bus environment.
interface ex_mem_dresp_if #(
    parameter int unsigned AddrW = 48
) ();

    logic             req_valid;
    logic             req_is_store;
    logic [1:0]       req_size;
    logic             req_sx;
    logic [AddrW-1:0] req_addr;
    logic [63:0]      req_data;
    logic             req_flush;

    logic [63:0]      mem_data_in;
    logic [63:0]      mem_data_in_b;
    logic [1:0]       mem_data_ok;

    logic             bus_req;
    logic             bus_we;
    logic [AddrW-1:0] bus_addr;
    logic [63:0]      bus_wdata;
    logic [7:0]       bus_mask;
    logic [63:0]      bus_rdata;
    logic             bus_ack;
    logic             bus_err;

    modport slave (
        input  req_valid, req_is_store, req_size, req_sx, req_addr, req_data, req_flush,
        input  bus_rdata, bus_ack, bus_err,
        output mem_data_in, mem_data_in_b, mem_data_ok,
        output bus_req, bus_we, bus_addr, bus_wdata, bus_mask
    );

    modport master (
        output req_valid, req_is_store, req_size, req_sx, req_addr, req_data, req_flush,
        output bus_rdata, bus_ack, bus_err,
        input  mem_data_in, mem_data_in_b, mem_data_ok,
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_mask
    );

endinterface

// File: rtl/ex_mem_dextract.sv
// Byte-lane datapath: load lane select with sign/zero extension, and store data/mask
// placement onto the 64-bit bus lane.
module ex_mem_dextract
    import ex_mem_dresp_pkg::*;
(
    input  logic [63:0] word_i,
    input  logic [2:0]  lane_i,
    input  size_e       size_i,
    input  logic        sx_i,
    input  logic [63:0] st_data_i,
    output logic [63:0] ld_data_o,
    output logic [63:0] st_data_o,
    output logic [7:0]  st_mask_o
);

    logic [63:0] shifted;

    always_comb begin
        shifted = word_i >> {lane_i, 3'b000};
        unique case (size_i)
            SizeB:   ld_data_o = {{56{sx_i & shifted[7]}},  shifted[7:0]};
            SizeW:   ld_data_o = {{48{sx_i & shifted[15]}}, shifted[15:0]};
            SizeL:   ld_data_o = {{32{sx_i & shifted[31]}}, shifted[31:0]};
            default: ld_data_o = shifted;
        endcase
        st_data_o = st_data_i << {lane_i, 3'b000};
        st_mask_o = size_mask(size_i) << lane_i;
    end

endmodule

// File: rtl/ex_mem_dresp.sv
// Data-memory responder for EX3: one bus transaction per load/store request, reports
// ready/hold/fault on mem_data_ok. Optional bus timeout via JX2_DRESP_TIMEOUT_EN.
module ex_mem_dresp
    import ex_mem_dresp_pkg::*;
#(
    parameter int unsigned AddrW      = 48,
    parameter int unsigned TimeoutCyc = 255
) (
    input logic           clk_i,
    input logic           rst_ni,
    ex_mem_dresp_if.slave io
);

    state_e           state_q, state_d;
    logic             is_store_q;
    size_e            size_q;
    logic             sx_q;
    logic [AddrW-1:0] addr_q;
    logic [63:0]      data_q;
    logic             drop_q, drop_d;
    logic [63:0]      ld_q, ld_b_q;
    logic             capture, latch;
    logic [63:0]      ld_data, st_data;
    logic [7:0]       st_mask;
    logic             issue;
`ifdef JX2_DRESP_TIMEOUT_EN
    logic [7:0]       cnt_q, cnt_d;
`endif

    ex_mem_dextract u_dextract (
        .word_i    (io.bus_rdata),
        .lane_i    (addr_q[2:0]),
        .size_i    (size_q),
        .sx_i      (sx_q),
        .st_data_i (data_q),
        .ld_data_o (ld_data),
        .st_data_o (st_data),
        .st_mask_o (st_mask)
    );

    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        capture = 1'b0;
        latch   = 1'b0;
`ifdef JX2_DRESP_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                drop_d = 1'b0;
                if (io.req_valid && !io.req_flush) begin
                    capture = 1'b1;
                    state_d = is_misaligned(size_e'(io.req_size), io.req_addr[2:0]) ?
                              StFault : StIssue;
                end
            end
            StIssue: begin
                drop_d  = drop_q | io.req_flush;
                state_d = StWait;
`ifdef JX2_DRESP_TIMEOUT_EN
                cnt_d   = 8'd0;
`endif
            end
            StWait: begin
                drop_d = drop_q | io.req_flush;
                if (io.bus_ack) begin
                    if (!io.bus_err) begin
                        latch   = !is_store_q;
                        state_d = StDone;
                    end else begin
                        // A flushed request has no consumer for the fault.
                        state_d = drop_d ? StIdle : StFault;
                    end
                end
`ifdef JX2_DRESP_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'(TimeoutCyc - 1)) begin
                        state_d = drop_d ? StIdle : StFault;
                    end
                end
`endif
            end
            StDone: state_d = StIdle;
            StFault: begin
                if (!io.req_valid || io.req_flush) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            is_store_q <= 1'b0;
            size_q     <= SizeB;
            sx_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            drop_q     <= 1'b0;
            ld_q       <= '0;
            ld_b_q     <= '0;
`ifdef JX2_DRESP_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
`ifdef JX2_DRESP_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
            if (capture) begin
                is_store_q <= io.req_is_store;
                size_q     <= size_e'(io.req_size);
                sx_q       <= io.req_sx;
                addr_q     <= io.req_addr;
                data_q     <= io.req_data;
            end
            if (latch) begin
                ld_q   <= ld_data;
                ld_b_q <= io.bus_rdata;
            end
        end
    end

    assign issue = (state_q == StIssue);

    always_comb begin
        unique case (state_q)
            StIdle:         io.mem_data_ok = (io.req_valid && !io.req_flush) ? OkHold : OkReady;
            StIssue, StWait: io.mem_data_ok = OkHold;
            StFault:        io.mem_data_ok = OkFault;
            default:        io.mem_data_ok = OkReady;
        endcase
    end

    // Bus fields are only meaningful during the single ISSUE strobe cycle.
    assign io.bus_req       = issue;
    assign io.bus_we        = issue & is_store_q;
    assign io.bus_addr      = issue ? {addr_q[AddrW-1:3], 3'b000} : '0;
    assign io.bus_wdata     = issue ? st_data : '0;
    assign io.bus_mask      = issue ? st_mask : '0;
    assign io.mem_data_in   = ld_q;
    assign io.mem_data_in_b = ld_b_q;

endmodule

// File: tb/tb_ex_mem_dresp.sv
// Scoreboard bench for ex_mem_dresp: stimulus pushes expected bus strobes and responses,
// a negedge monitor pops and compares them.
module tb_ex_mem_dresp;

    typedef struct {
        logic        we;
        logic [47:0] addr;
        logic [63:0] wdata;
        logic [7:0]  mask;
        int          cyc;
    } bus_exp_t;

    typedef struct {
        logic [1:0]  ok;
        logic        chk;
        logic [63:0] d;
        logic [63:0] db;
        int          cyc;
    } resp_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fails = 0;
    logic [1:0] prev_ok = 2'b00;

    bus_exp_t  bus_q[$];
    resp_exp_t resp_q[$];

    ex_mem_dresp_if dif ();

    ex_mem_dresp #(
        .AddrW      (48),
        .TimeoutCyc (8)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .io     (dif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ok = 2'b00;
        end else begin
            if (dif.bus_req) begin
                if (bus_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL bus_req_unexpected: got bus_req=1 at cycle %0d expected 0", cyc);
                end else begin
                    bus_exp_t e;
                    e = bus_q.pop_front();
                    chk("bus_cyc", 64'(cyc), 64'(e.cyc));
                    chk("bus_we", 64'(dif.bus_we), 64'(e.we));
                    chk("bus_addr", 64'(dif.bus_addr), 64'(e.addr));
                    chk("bus_wdata", dif.bus_wdata, e.wdata);
                    chk("bus_mask", 64'(dif.bus_mask), 64'(e.mask));
                end
            end
            if ((dif.mem_data_ok == 2'b11 && prev_ok != 2'b11) ||
                (dif.mem_data_ok == 2'b00 && prev_ok == 2'b10)) begin
                if (resp_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL resp_unexpected: got ok=%b at cycle %0d expected none",
                             dif.mem_data_ok, cyc);
                end else begin
                    resp_exp_t r;
                    r = resp_q.pop_front();
                    chk("resp_ok", 64'(dif.mem_data_ok), 64'(r.ok));
                    chk("resp_cyc", 64'(cyc), 64'(r.cyc));
                    if (r.chk) begin
                        chk("mem_data_in", dif.mem_data_in, r.d);
                        chk("mem_data_in_b", dif.mem_data_in_b, r.db);
                    end
                end
            end
            prev_ok = dif.mem_data_ok;
        end
    end

    task automatic run_req(input logic st, input logic [1:0] sz, input logic sx,
                           input logic [47:0] addr, input logic [63:0] wd,
                           input int ack_at, input logic err, input logic [63:0] rd,
                           input int flush_at, input int end_k,
                           input logic has_bus, input bus_exp_t be,
                           input logic has_resp, input resp_exp_t re);
        int t0;
        bus_exp_t  b;
        resp_exp_t r;
        @(posedge clk);
        #1;
        t0 = cyc;
        b = be;
        b.cyc = t0 + 1;
        r = re;
        r.cyc = t0 + re.cyc;
        if (has_bus) bus_q.push_back(b);
        if (has_resp) resp_q.push_back(r);
        dif.req_valid    = 1'b1;
        dif.req_is_store = st;
        dif.req_size     = sz;
        dif.req_sx       = sx;
        dif.req_addr     = addr;
        dif.req_data     = wd;
        for (int k = 0; k < end_k; k++) begin
            dif.bus_ack   = (k == ack_at);
            dif.bus_err   = (k == ack_at) & err;
            dif.bus_rdata = rd;
            dif.req_flush = (k == flush_at);
            @(posedge clk);
            #1;
        end
        dif.req_valid = 1'b0;
        dif.req_flush = 1'b0;
        dif.bus_ack   = 1'b0;
        dif.bus_err   = 1'b0;
    endtask

    task automatic expect_ok(input string name, input logic [1:0] e);
        @(negedge clk);
        chk(name, 64'(dif.mem_data_ok), 64'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dif.req_valid = 0; dif.req_is_store = 0; dif.req_size = 0; dif.req_sx = 0;
        dif.req_addr = '0; dif.req_data = '0; dif.req_flush = 0;
        dif.bus_rdata = '0; dif.bus_ack = 0; dif.bus_err = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ok", 64'(dif.mem_data_ok), 64'd0);
        chk("rst_bus_req", 64'(dif.bus_req), 64'd0);
        chk("rst_bus_we", 64'(dif.bus_we), 64'd0);
        chk("rst_bus_addr", 64'(dif.bus_addr), 64'd0);
        chk("rst_bus_wdata", dif.bus_wdata, 64'd0);
        chk("rst_bus_mask", 64'(dif.bus_mask), 64'd0);
        chk("rst_data", dif.mem_data_in, 64'd0);
        chk("rst_data_b", dif.mem_data_in_b, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Load Q, ack in cycle 4 -> ready in cycle 5
        run_req(0, 2'd3, 0, 48'h1000, 64'h0, 4, 0, 64'h0123456789ABCDEF, -1, 5,
                1, '{0, 48'h1000, 64'h0, 8'hff, 0},
                1, '{2'b00, 1, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 5});
        // Load B signed, lane 3, minimum latency
        run_req(0, 2'd0, 1, 48'h1003, 64'h0, 2, 0, 64'h0000000080000000, -1, 3,
                1, '{0, 48'h1000, 64'h0, 8'h08, 0},
                1, '{2'b00, 1, 64'hFFFFFFFFFFFFFF80, 64'h0000000080000000, 3});
        // Store W lane 6; load registers keep previous values
        run_req(1, 2'd1, 0, 48'h2006, 64'hBEEF, 3, 0, 64'hDEADDEADDEADDEAD, -1, 4,
                1, '{1, 48'h2000, 64'hBEEF000000000000, 8'hc0, 0},
                1, '{2'b00, 1, 64'hFFFFFFFFFFFFFF80, 64'h0000000080000000, 4});
        // Load W unsigned, lane 2
        run_req(0, 2'd1, 0, 48'h4002, 64'h0, 3, 0, 64'h1122334455668899, -1, 4,
                1, '{0, 48'h4000, 64'h0, 8'h0c, 0},
                1, '{2'b00, 1, 64'h0000000000005566, 64'h1122334455668899, 4});
        // Load L signed, lane 4
        run_req(0, 2'd2, 1, 48'h4004, 64'h0, 2, 0, 64'h8000000112345678, -1, 3,
                1, '{0, 48'h4000, 64'h0, 8'hf0, 0},
                1, '{2'b00, 1, 64'hFFFFFFFF80000001, 64'h8000000112345678, 3});
        // Misaligned load L: fault next cycle, no bus strobe
        run_req(0, 2'd2, 0, 48'h3002, 64'h0, -1, 0, 64'h0, -1, 3,
                0, '{0, 48'h0, 64'h0, 8'h0, 0},
                1, '{2'b11, 0, 64'h0, 64'h0, 1});
        expect_ok("misalign_held", 2'b11);
        @(posedge clk);
        expect_ok("misalign_release", 2'b00);
        // Bus error on load
        run_req(0, 2'd3, 0, 48'h5000, 64'h0, 3, 1, 64'h0, -1, 6,
                1, '{0, 48'h5000, 64'h0, 8'hff, 0},
                1, '{2'b11, 0, 64'h0, 64'h0, 4});
        expect_ok("buserr_held", 2'b11);
        @(posedge clk);
        expect_ok("buserr_release", 2'b00);
        // Bus error under flush in WAIT: ready, never fault, data unchanged
        run_req(0, 2'd3, 0, 48'h5008, 64'h0, 4, 1, 64'h0, 2, 5,
                1, '{0, 48'h5008, 64'h0, 8'hff, 0},
                1, '{2'b00, 1, 64'hFFFFFFFF80000001, 64'h8000000112345678, 5});
        // Flush in ISSUE: transaction completes, load registers still update
        run_req(0, 2'd0, 0, 48'h6001, 64'h0, 3, 0, 64'h000000000000AB00, 1, 4,
                1, '{0, 48'h6000, 64'h0, 8'h02, 0},
                1, '{2'b00, 1, 64'h00000000000000AB, 64'h000000000000AB00, 4});
        // Store B lane 3
        run_req(1, 2'd0, 0, 48'h2003, 64'hA5, 2, 0, 64'h0, -1, 3,
                1, '{1, 48'h2000, 64'h00000000A5000000, 8'h08, 0},
                1, '{2'b00, 1, 64'h00000000000000AB, 64'h000000000000AB00, 3});

        // Flush together with a request in IDLE: ignored
        @(posedge clk);
        #1;
        dif.req_valid = 1'b1;
        dif.req_flush = 1'b1;
        dif.req_addr  = 48'h9000;
        expect_ok("idle_flush_ok", 2'b00);
        chk("idle_flush_busreq", 64'(dif.bus_req), 64'd0);
        @(posedge clk);
        #1;
        dif.req_valid = 1'b0;
        dif.req_flush = 1'b0;
        expect_ok("idle_flush_after", 2'b00);

        // No ack: timeout fault 8 cycles after WAIT entry, or indefinite hold
`ifdef JX2_DRESP_TIMEOUT_EN
        run_req(0, 2'd3, 0, 48'h7000, 64'h0, -1, 0, 64'h0, -1, 12,
                1, '{0, 48'h7000, 64'h0, 8'hff, 0},
                1, '{2'b11, 0, 64'h0, 64'h0, 10});
        expect_ok("timeout_held", 2'b11);
        @(posedge clk);
        expect_ok("timeout_release", 2'b00);
        run_req(0, 2'd3, 0, 48'h7008, 64'h0, -1, 0, 64'h0, -1, 3,
                1, '{0, 48'h7008, 64'h0, 8'hff, 0},
                0, '{2'b00, 0, 64'h0, 64'h0, 0});
`else
        run_req(0, 2'd3, 0, 48'h7000, 64'h0, -1, 0, 64'h0, -1, 12,
                1, '{0, 48'h7000, 64'h0, 8'hff, 0},
                0, '{2'b00, 0, 64'h0, 64'h0, 0});
        expect_ok("no_timeout_hold", 2'b10);
`endif

        // Reset mid-transaction, then a late ack must be ignored
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ok", 64'(dif.mem_data_ok), 64'd0);
        chk("midrst_busreq", 64'(dif.bus_req), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dif.bus_ack   = 1'b1;
        dif.bus_rdata = 64'hCAFEF00DCAFEF00D;
        @(posedge clk);
        #1;
        dif.bus_ack = 1'b0;
        expect_ok("late_ack_ok", 2'b00);
        chk("late_ack_data", dif.mem_data_in, 64'd0);
        chk("late_ack_data_b", dif.mem_data_in_b, 64'd0);
        repeat (2) @(posedge clk);
        expect_ok("late_ack_idle", 2'b00);

        chk("bus_q_empty", 64'(bus_q.size()), 64'd0);
        chk("resp_q_empty", 64'(resp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
